// File: rtl/sec_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sec_pkg
// Brief   : Shared command/key encodings and FSM states for the keypad sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package sec_pkg;

  localparam logic [1:0] CMD_NONE   = 2'b00;
  localparam logic [1:0] CMD_ARM    = 2'b01;
  localparam logic [1:0] CMD_DISARM = 2'b10;

  localparam logic [3:0] KEY_ARM    = 4'hA;
  localparam logic [3:0] KEY_DISARM = 4'hB;
  localparam logic [3:0] KEY_CLEAR  = 4'hC;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXIT    = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CHECK   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sec_countdown.sv
`default_nettype none
// ============================================================================
// Module  : sec_countdown
// Brief   : Loadable down-counter; done is high while the count sits at zero.
// Revision: 1.0 - initial release
// ============================================================================
module sec_countdown #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= value_i;
    end else if (count_q != '0) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign done_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sec_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sec_keypad_ctrl
// Brief   : Keypad code collector, exit delay, code replay and failed-disarm lockout.
// Revision: 1.0 - initial release
// ============================================================================
module sec_keypad_ctrl
  import sec_pkg::*;
#(
  parameter int PIN_LEN        = 4,
  parameter int EXIT_DELAY     = 16,
  parameter int MAX_FAIL       = 3,
  parameter int LOCKOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid_i,
  input  logic [3:0] key_code_i,
  input  logic       core_armed_i,
  input  logic       core_alarm_i,
  output logic [3:0] digit_o,
  output logic       input_digit_o,
  output logic [1:0] command_o,
  output logic       busy_o,
  output logic       exit_pending_o,
  output logic       locked_o,
  output logic       error_o,
  output logic [1:0] fail_count_o
);

  localparam int TMR_MAX = (EXIT_DELAY > LOCKOUT_CYCLES) ? EXIT_DELAY : LOCKOUT_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_W   = $clog2(PIN_LEN + 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [3:0]       pin_q [PIN_LEN];
  logic [3:0]       pin_d [PIN_LEN];
  logic [1:0]       op_q, op_d, fail_q, fail_d, cmd_q, cmd_d;
  logic [3:0]       digit_q, digit_d;
  logic             indig_q, indig_d, err_q, err_d;
  logic             tmr_load, tmr_done;
  logic [TMR_W-1:0] tmr_val;

  sec_countdown #(.WIDTH(TMR_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .load_i  (tmr_load),
    .value_i (tmr_val),
    .done_o  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      op_q    <= CMD_NONE;
      fail_q  <= '0;
      cmd_q   <= CMD_NONE;
      digit_q <= '0;
      indig_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < PIN_LEN; i++) pin_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      op_q    <= op_d;
      fail_q  <= fail_d;
      cmd_q   <= cmd_d;
      digit_q <= digit_d;
      indig_q <= indig_d;
      err_q   <= err_d;
      pin_q   <= pin_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    op_d     = op_q;
    fail_d   = fail_q;
    pin_d    = pin_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    digit_d  = '0;
    indig_d  = 1'b0;
    cmd_d    = CMD_NONE;

    case (state_q)
      ST_IDLE: begin
        if (key_valid_i) begin
          if (is_digit(key_code_i)) begin
            if (cnt_q < IDX_W'(PIN_LEN)) begin
              for (int i = 0; i < PIN_LEN; i++)
                if (cnt_q == IDX_W'(i)) pin_d[i] = key_code_i;
              cnt_d = cnt_q + IDX_W'(1);
            end
          end else if (key_code_i == KEY_CLEAR) begin
            cnt_d = '0;
          end else if (key_code_i == KEY_ARM) begin
            if (cnt_q == IDX_W'(PIN_LEN) && !core_alarm_i) begin
              state_d  = ST_EXIT;
              tmr_load = 1'b1;
              tmr_val  = TMR_W'(EXIT_DELAY - 1);
            end else begin
              err_d = 1'b1;
              cnt_d = '0;
            end
          end else if (key_code_i == KEY_DISARM) begin
            if (cnt_q == IDX_W'(PIN_LEN)) begin
              state_d = ST_ISSUE;
              idx_d   = '0;
              op_d    = CMD_DISARM;
            end else begin
              err_d = 1'b1;
              cnt_d = '0;
            end
          end
        end
      end
      ST_EXIT: begin
        // CLEAR beats expiry even on the last delay cycle
        if (key_valid_i && key_code_i == KEY_CLEAR) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (tmr_done) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          op_d    = CMD_ARM;
        end
      end
      ST_ISSUE: begin
        if (idx_q == IDX_W'(PIN_LEN)) begin
          cnt_d   = '0;
          state_d = (op_q == CMD_DISARM) ? ST_CHECK : ST_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_CHECK: begin
        state_d = ST_IDLE;
        if (core_armed_i) begin
          if (fail_q >= 2'(MAX_FAIL - 1)) begin
            fail_d   = 2'(MAX_FAIL);
            state_d  = ST_LOCKOUT;
            tmr_load = 1'b1;
            tmr_val  = TMR_W'(LOCKOUT_CYCLES - 1);
          end else begin
            fail_d = fail_q + 2'd1;
          end
        end else begin
          fail_d = '0;
        end
      end
      ST_LOCKOUT: begin
        if (tmr_done) begin
          fail_d  = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Replay outputs are decoded from the next state so the registers line up with it
    if (state_d == ST_ISSUE) begin
      if (idx_d == IDX_W'(PIN_LEN)) begin
        cmd_d = op_d;
      end else begin
        indig_d = 1'b1;
        for (int i = 0; i < PIN_LEN; i++)
          if (idx_d == IDX_W'(i)) digit_d = pin_d[i];
      end
    end
  end

  assign digit_o        = digit_q;
  assign input_digit_o  = indig_q;
  assign command_o      = cmd_q;
  assign error_o        = err_q;
  assign fail_count_o   = fail_q;
  assign exit_pending_o = (state_q == ST_EXIT);
  assign locked_o       = (state_q == ST_LOCKOUT);
  assign busy_o         = (state_q == ST_EXIT) || (state_q == ST_ISSUE) || (state_q == ST_CHECK);

endmodule
`default_nettype wire

// File: tb/tb_sec_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sec_keypad_ctrl
// Brief   : Directed and random keypad traffic checked against a time-window model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sec_keypad_ctrl;

  localparam int PIN_LEN = 4, EXIT_DELAY = 16, MAX_FAIL = 3, LOCKOUT_CYCLES = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, key_valid = 1'b0, core_armed = 1'b0, core_alarm = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic [3:0] digit;
  logic       input_digit, busy, exit_pending, locked, error;
  logic [1:0] command, fail_count;

  sec_keypad_ctrl #(
    .PIN_LEN(PIN_LEN), .EXIT_DELAY(EXIT_DELAY),
    .MAX_FAIL(MAX_FAIL), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .key_valid_i    (key_valid),
    .key_code_i     (key_code),
    .core_armed_i   (core_armed),
    .core_alarm_i   (core_alarm),
    .digit_o        (digit),
    .input_digit_o  (input_digit),
    .command_o      (command),
    .busy_o         (busy),
    .exit_pending_o (exit_pending),
    .locked_o       (locked),
    .error_o        (error),
    .fail_count_o   (fail_count)
  );

  int n_cmp = 0, n_bad = 0, t = 0;
  logic arm_n = 1'b0, alarm_n = 1'b0;

  // Model: activity is a set of absolute cycle windows; idle means no window covers t
  int         ex_s = 0, ex_e = -1, rp_s = 0, ck = -1, lk_s = 0, lk_e = -1, err_t = -1, fail = 0;
  bit         rp_on = 1'b0;
  logic [1:0] rp_op = 2'b00;
  logic [3:0] code [PIN_LEN];
  logic [3:0] keyq [$];

  logic [15:0] mon_dig;
  logic [1:0]  mon_cmd;
  int          mon_ndig, mon_ncmd, mon_exit, mon_lock, mon_err;

  function automatic bit m_in(input int a, input int lo, input int hi);
    return (a >= lo) && (a <= hi);
  endfunction

  function automatic bit m_idle(input int tt);
    return !(m_in(tt, ex_s, ex_e) || (rp_on && m_in(tt, rp_s, rp_s + PIN_LEN)) ||
             tt == ck || m_in(tt, lk_s, lk_e));
  endfunction

  function automatic logic [12:0] m_out(input int tt);
    logic [3:0] d = 4'h0;
    logic       id = 1'b0, ex, lk, by;
    logic [1:0] cm = 2'b00;
    int         k = tt - rp_s;
    if (rp_on && k >= 0 && k < PIN_LEN) begin
      id = 1'b1;
      d  = code[k];
    end else if (rp_on && k == PIN_LEN) begin
      cm = rp_op;
    end
    ex = m_in(tt, ex_s, ex_e);
    lk = m_in(tt, lk_s, lk_e);
    by = ex || (rp_on && m_in(tt, rp_s, rp_s + PIN_LEN)) || (tt == ck);
    return {d, id, cm, by, ex, lk, (tt == err_t), 2'(fail)};
  endfunction

  task automatic m_step(input int tt, input bit r, input bit kv, input logic [3:0] kc,
                        input bit armed, input bit alarm);
    if (r) begin
      ex_s = 0; ex_e = -1; rp_on = 1'b0; ck = -1; lk_s = 0; lk_e = -1; err_t = -1; fail = 0;
      keyq.delete();
      return;
    end
    if (tt == ck) begin
      if (armed) begin
        fail++;
        if (fail >= MAX_FAIL) begin
          lk_s = tt + 1;
          lk_e = tt + LOCKOUT_CYCLES;
        end
      end else fail = 0;
    end
    if (tt == lk_e) fail = 0;
    if (m_in(tt, ex_s, ex_e)) begin
      if (kv && kc == 4'hC) begin
        ex_e  = tt;
        rp_on = 1'b0;
      end
    end else if (m_idle(tt) && kv) begin
      if (kc <= 4'd9) begin
        if (keyq.size() < PIN_LEN) keyq.push_back(kc);
      end else if (kc == 4'hC) begin
        keyq.delete();
      end else if (kc == 4'hA || kc == 4'hB) begin
        if (keyq.size() == PIN_LEN && (kc == 4'hB || !alarm)) begin
          for (int i = 0; i < PIN_LEN; i++) code[i] = keyq[i];
          rp_on = 1'b1;
          if (kc == 4'hA) begin
            ex_s = tt + 1; ex_e = tt + EXIT_DELAY; rp_s = tt + EXIT_DELAY + 1; rp_op = 2'b01;
          end else begin
            rp_s = tt + 1; rp_op = 2'b10; ck = tt + PIN_LEN + 2;
          end
        end else begin
          err_t = tt + 1;
        end
        keyq.delete();
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit kv, input logic [3:0] kc);
    logic [12:0] act, exp;
    @(posedge clk);
    #1;
    reset = r; key_valid = kv; key_code = kc; core_armed = arm_n; core_alarm = alarm_n;
    @(negedge clk);
    act = {digit, input_digit, command, busy, exit_pending, locked, error, fail_count};
    exp = m_out(t);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL outputs cycle %0d: got %h, expected %h (dig,id,cmd,busy,exit,lock,err,fail)",
               t, act, exp);
    end
    if (input_digit) begin mon_dig = {mon_dig[11:0], digit}; mon_ndig++; end
    if (command != 2'b00) begin mon_cmd = command; mon_ncmd++; end
    if (exit_pending) mon_exit++;
    if (locked) mon_lock++;
    if (error) mon_err++;
    m_step(t, r, kv, kc, core_armed, core_alarm);
    t++;
  endtask

  task automatic press(input logic [3:0] k);
    cyc(1'b0, 1'b1, k);
    cyc(1'b0, 1'b0, 4'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 4'h0);
  endtask

  task automatic clr_mon();
    mon_dig = '0; mon_cmd = 2'b00;
    mon_ndig = 0; mon_ncmd = 0; mon_exit = 0; mon_lock = 0; mon_err = 0;
  endtask

  initial begin
    clr_mon();
    repeat (3) cyc(1'b1, 1'b0, 4'h0);
    check("reset_outputs",
          int'({digit, input_digit, command, busy, exit_pending, locked, error, fail_count}), 0);

    // Disarm with core disarmed
    clr_mon();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);
    idle(8);
    check("disarm_digits", int'(mon_dig), 'h1234);
    check("disarm_ndig", mon_ndig, 4);
    check("disarm_cmd", int'(mon_cmd), 2);
    check("disarm_ncmd", mon_ncmd, 1);
    check("disarm_fail", int'(fail_count), 0);

    // Arm with exit delay
    clr_mon();
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'hA);
    idle(30);
    check("arm_exit_cycles", mon_exit, 16);
    check("arm_digits", int'(mon_dig), 'h5678);
    check("arm_cmd", int'(mon_cmd), 1);
    check("arm_ncmd", mon_ncmd, 1);

    // CLEAR on the final exit cycle aborts
    clr_mon();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    cyc(1'b0, 1'b1, 4'hA);
    idle(15);
    cyc(1'b0, 1'b1, 4'hC);
    idle(25);
    check("abort_exit_cycles", mon_exit, 16);
    check("abort_ndig", mon_ndig, 0);
    check("abort_ncmd", mon_ncmd, 0);
    press(4'hB);
    check("abort_cnt_cleared_err", mon_err, 1);

    // Short code rejected, then overflow digits dropped
    clr_mon();
    press(4'h1); press(4'h2); press(4'hA);
    check("short_err", mon_err, 1);
    check("short_ncmd", mon_ncmd, 0);
    repeat (5) press(4'h9);
    press(4'hB);
    idle(8);
    check("overflow_digits", int'(mon_dig), 'h9999);
    check("overflow_ndig", mon_ndig, 4);

    // Three failed disarms lead to lockout
    arm_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) clr_mon();
      press(4'h1); press(4'h2); press(4'h3); press(4'h4);
      cyc(1'b0, 1'b1, 4'hB);
      idle(7);
      check("fail_count_step", int'(fail_count), k);
    end
    check("lock_started", int'(locked), 1);
    for (int i = 0; i < 63; i++) cyc(1'b0, 1'b1, 4'(8 + $urandom_range(0, 7)));
    idle(3);
    check("lock_cycles", mon_lock, 64);
    check("lock_no_err", mon_err, 0);
    check("lock_fail_cleared", int'(fail_count), 0);
    arm_n = 1'b0;
    clr_mon();
    press(4'h0); press(4'h0); press(4'h0); press(4'h0); press(4'hB);
    idle(8);
    check("post_lock_ndig", mon_ndig, 4);
    check("post_lock_cmd", int'(mon_cmd), 2);

    // Reset during the second replayed digit
    clr_mon();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    cyc(1'b0, 1'b1, 4'hB);
    cyc(1'b0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 4'h0);
    cyc(1'b0, 1'b0, 4'h0);
    check("reset_mid_replay_outputs",
          int'({digit, input_digit, command, busy, exit_pending, locked, error, fail_count}), 0);
    idle(10);
    check("reset_mid_replay_ndig", mon_ndig, 2);
    check("reset_mid_replay_ncmd", mon_ncmd, 0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic [3:0] kc;
      if ($urandom_range(0, 99) == 0) arm_n = ~arm_n;
      alarm_n = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 3) == 0) kc = 4'(4'hA + $urandom_range(0, 2));
      else kc = 4'($urandom_range(0, 15));
      cyc(($urandom_range(0, 599) == 0), ($urandom_range(0, 2) == 0), kc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
